tts_rcb_cfg_ctrl: RTL and testbench

//  Host-side configuration controller for the Strategy RCBs (symbol, price, volume, order).

---
 rtl/tts_pkg.sv | 63 ++++++
 rtl/tts_rcb_cfg_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_tts_rcb_cfg_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// -----------------------------------------------------------------------------
// tts_pkg
// Shared types for the Strategy RCB configuration path: the host message
// layout, RAM (RCB) selector encoding, command/status/state enums and the
// helper that turns a RAM selector into a one-hot RCB request vector.
// No ports (package).
// -----------------------------------------------------------------------------
package tts_pkg;

    localparam int NUM_RCB    = 4;
    localparam int RCB_DATA_W = 192;
    localparam int RCB_BE_W   = 24;
    localparam int RCB_ADDR_W = 16;

    // RAM selector as carried in the host message; only single-bit values
    // name a real RCB, anything else is a decode error.
    typedef logic [7:0] t_RAM_ENCODING;
    localparam t_RAM_ENCODING RAM_SRCB = 8'h01;
    localparam t_RAM_ENCODING RAM_PRCB = 8'h02;
    localparam t_RAM_ENCODING RAM_VRCB = 8'h04;
    localparam t_RAM_ENCODING RAM_ORCB = 8'h08;

    typedef enum logic [7:0] {
        CMD_WRITE = 8'h01,
        CMD_READ  = 8'h02
    } t_cfg_cmd;

    typedef enum logic [1:0] {
        ST_OK         = 2'd0,
        ST_DECODE_ERR = 2'd1,
        ST_TIMEOUT    = 2'd2
    } t_cfg_status;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2,
        RESP   = 2'd3
    } t_cfg_state;

    // addr is 17 bits so an out-of-range bit 16 can be detected.
    typedef struct packed {
        logic [7:0]            cmd;
        t_RAM_ENCODING         ram;
        logic [6:0]            res;
        logic [16:0]           addr;
        logic [RCB_BE_W-1:0]   byte_en;
        logic [RCB_DATA_W-1:0] data;
    } t_host_msg_map;

    function automatic logic [NUM_RCB-1:0] ram_to_onehot(input t_RAM_ENCODING ram);
        logic [NUM_RCB-1:0] onehot;
        case (ram)
            RAM_SRCB: onehot = 4'b0001;
            RAM_PRCB: onehot = 4'b0010;
            RAM_VRCB: onehot = 4'b0100;
            RAM_ORCB: onehot = 4'b1000;
            default:  onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/tts_rcb_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tts_rcb_cfg_ctrl
// Host-side configuration controller for the four Strategy RCBs. Takes one
// host message at a time, decodes it, issues a single read or write on the
// selected RCB, waits for that RCB's ack and returns a status/data response.
//
// Optional feature macro: TTS_CFG_TIMEOUT_EN -- adds an ack timeout counter
// (TIMEOUT_CYCLES) that aborts ISSUE with status ST_TIMEOUT.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   host_valid/ready/msg   host message handshake and packed message
//   rsp_valid/ready        response handshake
//   rsp_status, rsp_data   response status (t_cfg_status) and read data
//   rcb_req (one-hot), rcb_we, rcb_addr, rcb_byte_en, rcb_wdata
//                          request to the RCBs, stable until acked
//   rcb_ack, rcb_rdata     per-RCB ack pulse and read data
// -----------------------------------------------------------------------------
module tts_rcb_cfg_ctrl
    import tts_pkg::*;
#(
    parameter int RCB_DEPTH = 4096
`ifdef TTS_CFG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                host_valid,
    output logic                                host_ready,
    input  t_host_msg_map                       host_msg,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [1:0]                          rsp_status,
    output logic [RCB_DATA_W-1:0]               rsp_data,
    output logic [NUM_RCB-1:0]                  rcb_req,
    output logic                                rcb_we,
    output logic [RCB_ADDR_W-1:0]               rcb_addr,
    output logic [RCB_BE_W-1:0]                 rcb_byte_en,
    output logic [RCB_DATA_W-1:0]               rcb_wdata,
    input  logic [NUM_RCB-1:0]                  rcb_ack,
    input  logic [NUM_RCB-1:0][RCB_DATA_W-1:0]  rcb_rdata
);

    localparam logic [16:0] DEPTH_LIM = 17'(RCB_DEPTH);

    t_cfg_state            state_q,       state_d;
    logic                  host_ready_q,  host_ready_d;
    logic [7:0]            cmd_q,         cmd_d;
    t_RAM_ENCODING         ram_q,         ram_d;
    logic                  addr_hi_q,     addr_hi_d;
    logic [NUM_RCB-1:0]    rcb_req_q,     rcb_req_d;
    logic                  rcb_we_q,      rcb_we_d;
    logic [RCB_ADDR_W-1:0] rcb_addr_q,    rcb_addr_d;
    logic [RCB_BE_W-1:0]   rcb_byte_en_q, rcb_byte_en_d;
    logic [RCB_DATA_W-1:0] rcb_wdata_q,   rcb_wdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    t_cfg_status           rsp_status_q,  rsp_status_d;
    logic [RCB_DATA_W-1:0] rsp_data_q,    rsp_data_d;

    logic                  dec_err_s;
    logic                  ack_hit_s;
    logic [RCB_DATA_W-1:0] sel_rdata_s;
    logic                  unused_res_s;

`ifdef TTS_CFG_TIMEOUT_EN
    localparam int          CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    // The reserved field carries no meaning for this block.
    assign unused_res_s = ^host_msg.res;

    // Decode, ack detection and the whole next-state / output computation.
    always_comb begin
        state_d       = state_q;
        host_ready_d  = host_ready_q;
        cmd_d         = cmd_q;
        ram_d         = ram_q;
        addr_hi_d     = addr_hi_q;
        rcb_req_d     = rcb_req_q;
        rcb_we_d      = rcb_we_q;
        rcb_addr_d    = rcb_addr_q;
        rcb_byte_en_d = rcb_byte_en_q;
        rcb_wdata_d   = rcb_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_data_d    = rsp_data_q;
`ifdef TTS_CFG_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif

        dec_err_s = ((cmd_q != CMD_WRITE) && (cmd_q != CMD_READ))
                 || (ram_to_onehot(ram_q) == 4'b0000)
                 || (addr_hi_q != 1'b0)
                 || ({1'b0, rcb_addr_q} >= DEPTH_LIM);

        // Only the lane we requested can complete the transaction.
        ack_hit_s = |(rcb_ack & rcb_req_q);

        // And-or mux: rcb_req_q is one-hot during ISSUE.
        sel_rdata_s = {RCB_DATA_W{1'b0}};
        for (int i = 0; i < NUM_RCB; i++) begin
            sel_rdata_s = sel_rdata_s | (rcb_rdata[i] & {RCB_DATA_W{rcb_req_q[i]}});
        end

        case (state_q)
            IDLE: begin
                if (host_valid && host_ready_q) begin
                    // RCB-facing fields are loaded now; they only matter once
                    // rcb_req rises, and stay put until the next accept.
                    cmd_d         = host_msg.cmd;
                    ram_d         = host_msg.ram;
                    addr_hi_d     = host_msg.addr[16];
                    rcb_we_d      = (host_msg.cmd == CMD_WRITE);
                    rcb_addr_d    = host_msg.addr[15:0];
                    rcb_byte_en_d = host_msg.byte_en;
                    rcb_wdata_d   = host_msg.data;
                    host_ready_d  = 1'b0;
                    state_d       = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                if (dec_err_s) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_DECODE_ERR;
                    rsp_data_d   = {RCB_DATA_W{1'b0}};
                    state_d      = RESP;
                end else begin
                    rcb_req_d = ram_to_onehot(ram_q);
`ifdef TTS_CFG_TIMEOUT_EN
                    cnt_d     = {CNT_W{1'b0}};
`endif
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // An ack in the timeout cycle still counts as success.
                if (ack_hit_s) begin
                    rcb_req_d    = {NUM_RCB{1'b0}};
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = rcb_we_q ? {RCB_DATA_W{1'b0}} : sel_rdata_s;
                    state_d      = RESP;
                end
`ifdef TTS_CFG_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rcb_req_d    = {NUM_RCB{1'b0}};
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_data_d   = {RCB_DATA_W{1'b0}};
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`else
                else begin
                    state_d = ISSUE;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    host_ready_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rcb_req_d    = {NUM_RCB{1'b0}};
                rsp_valid_d  = 1'b0;
                host_ready_d = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            host_ready_q  <= 1'b1;
            cmd_q         <= 8'h00;
            ram_q         <= 8'h00;
            addr_hi_q     <= 1'b0;
            rcb_req_q     <= {NUM_RCB{1'b0}};
            rcb_we_q      <= 1'b0;
            rcb_addr_q    <= {RCB_ADDR_W{1'b0}};
            rcb_byte_en_q <= {RCB_BE_W{1'b0}};
            rcb_wdata_q   <= {RCB_DATA_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_data_q    <= {RCB_DATA_W{1'b0}};
`ifdef TTS_CFG_TIMEOUT_EN
            cnt_q         <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            host_ready_q  <= host_ready_d;
            cmd_q         <= cmd_d;
            ram_q         <= ram_d;
            addr_hi_q     <= addr_hi_d;
            rcb_req_q     <= rcb_req_d;
            rcb_we_q      <= rcb_we_d;
            rcb_addr_q    <= rcb_addr_d;
            rcb_byte_en_q <= rcb_byte_en_d;
            rcb_wdata_q   <= rcb_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_data_q    <= rsp_data_d;
`ifdef TTS_CFG_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign host_ready  = host_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_data    = rsp_data_q;
    assign rcb_req     = rcb_req_q;
    assign rcb_we      = rcb_we_q;
    assign rcb_addr    = rcb_addr_q;
    assign rcb_byte_en = rcb_byte_en_q;
    assign rcb_wdata   = rcb_wdata_q;

endmodule

// File: tb/tb_tts_rcb_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tts_rcb_cfg_ctrl
// Directed self-checking bench for tts_rcb_cfg_ctrl. Inputs are driven and
// outputs sampled on the falling edge; cycle N below means the interval that
// follows rising edge N-1 (the accept edge is cycle 0).
// With TTS_CFG_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8 and
// the timeout scenario is exercised as well.
// -----------------------------------------------------------------------------
module tb_tts_rcb_cfg_ctrl;
    import tts_pkg::*;

    logic                                clk;
    logic                                rst_n;
    logic                                host_valid;
    logic                                host_ready;
    t_host_msg_map                       host_msg;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [1:0]                          rsp_status;
    logic [RCB_DATA_W-1:0]               rsp_data;
    logic [NUM_RCB-1:0]                  rcb_req;
    logic                                rcb_we;
    logic [RCB_ADDR_W-1:0]               rcb_addr;
    logic [RCB_BE_W-1:0]                 rcb_byte_en;
    logic [RCB_DATA_W-1:0]               rcb_wdata;
    logic [NUM_RCB-1:0]                  rcb_ack;
    logic [NUM_RCB-1:0][RCB_DATA_W-1:0]  rcb_rdata;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [RCB_DATA_W-1:0] d_pat;
    logic [RCB_DATA_W-1:0] a5_pat;
    logic [RCB_DATA_W-1:0] bp_pat;
    logic [RCB_DATA_W-1:0] v_pat;
    logic [RCB_DATA_W-1:0] zero192;

`ifdef TTS_CFG_TIMEOUT_EN
    tts_rcb_cfg_ctrl #(.RCB_DEPTH(4096), .TIMEOUT_CYCLES(8)) dut (
`else
    tts_rcb_cfg_ctrl #(.RCB_DEPTH(4096)) dut (
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_msg    (host_msg),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_data    (rsp_data),
        .rcb_req     (rcb_req),
        .rcb_we      (rcb_we),
        .rcb_addr    (rcb_addr),
        .rcb_byte_en (rcb_byte_en),
        .rcb_wdata   (rcb_wdata),
        .rcb_ack     (rcb_ack),
        .rcb_rdata   (rcb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic t_host_msg_map mk(input logic [7:0] cmd, input logic [7:0] ram,
                                         input logic [16:0] addr, input logic [23:0] be,
                                         input logic [191:0] data);
        t_host_msg_map m;
        m.cmd     = cmd;
        m.ram     = ram;
        m.res     = 7'h55;
        m.addr    = addr;
        m.byte_en = be;
        m.data    = data;
        return m;
    endfunction

    // Present one message for the accept edge; returns in cycle 1 (DECODE).
    task automatic send(input string tag, input t_host_msg_map m);
        chk({tag, "_host_ready"}, 192'(host_ready), 192'(1'b1));
        host_msg   = m;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
    endtask

    task automatic dec_err_case(input string tag, input t_host_msg_map m);
        send(tag, m);
        chk({tag, "_c1_rsp_valid"}, 192'(rsp_valid), 192'(1'b0));
        step();
        chk({tag, "_c2_rsp_valid"}, 192'(rsp_valid), 192'(1'b1));
        chk({tag, "_c2_status"}, 192'(rsp_status), 192'(2'd1));
        chk({tag, "_c2_data"}, rsp_data, zero192);
        chk({tag, "_c2_req"}, 192'(rcb_req), 192'(4'b0000));
        step();
        chk({tag, "_idle_ready"}, 192'(host_ready), 192'(1'b1));
    endtask

    initial begin
        d_pat   = {6{32'hDEADBEEF}};
        a5_pat  = {24{8'hA5}};
        bp_pat  = {12{16'h1234}};
        v_pat   = {6{32'h0BADF00D}};
        zero192 = {192{1'b0}};

        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_msg   = mk(8'h00, 8'h00, 17'h00000, 24'h000000, zero192);
        rsp_ready  = 1'b1;
        rcb_ack    = 4'b0000;
        for (int i = 0; i < NUM_RCB; i++) rcb_rdata[i] = {192{1'b0}};

        // Reset values
        step();
        chk("rst_host_ready", 192'(host_ready), 192'(1'b1));
        chk("rst_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        chk("rst_rcb_req", 192'(rcb_req), 192'(4'b0000));
        chk("rst_rcb_we", 192'(rcb_we), 192'(1'b0));
        chk("rst_rcb_wdata", rcb_wdata, zero192);
        rst_n = 1'b1;
        step();

        // 1. WRITE PRCB addr 0x10, ack at cycle 5
        send("wr", mk(8'h01, 8'h02, 17'h00010, 24'hFFFFFF, d_pat));
        chk("wr_c1_req", 192'(rcb_req), 192'(4'b0000));
        step();
        chk("wr_c2_req", 192'(rcb_req), 192'(4'b0010));
        chk("wr_c2_we", 192'(rcb_we), 192'(1'b1));
        chk("wr_c2_addr", 192'(rcb_addr), 192'(16'h0010));
        chk("wr_c2_be", 192'(rcb_byte_en), 192'(24'hFFFFFF));
        chk("wr_c2_wdata", rcb_wdata, d_pat);
        chk("wr_c2_host_ready", 192'(host_ready), 192'(1'b0));
        step();
        chk("wr_c3_req", 192'(rcb_req), 192'(4'b0010));
        step();
        step();
        chk("wr_c5_req", 192'(rcb_req), 192'(4'b0010));
        chk("wr_c5_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        rcb_ack = 4'b0010;
        rcb_rdata[1] = v_pat;
        step();
        rcb_ack = 4'b0000;
        rcb_rdata[1] = zero192;
        chk("wr_c6_req", 192'(rcb_req), 192'(4'b0000));
        chk("wr_c6_rsp_valid", 192'(rsp_valid), 192'(1'b1));
        chk("wr_c6_status", 192'(rsp_status), 192'(2'd0));
        chk("wr_c6_data", rsp_data, zero192);
        step();
        chk("wr_c7_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        chk("wr_c7_host_ready", 192'(host_ready), 192'(1'b1));

        // 2. READ ORCB addr 0x0FFF (last legal entry)
        send("rd", mk(8'h02, 8'h08, 17'h00FFF, 24'h000000, zero192));
        step();
        chk("rd_c2_req", 192'(rcb_req), 192'(4'b1000));
        chk("rd_c2_we", 192'(rcb_we), 192'(1'b0));
        chk("rd_c2_addr", 192'(rcb_addr), 192'(16'h0FFF));
        rcb_ack = 4'b1000;
        rcb_rdata[3] = a5_pat;
        rcb_rdata[0] = d_pat;
        rcb_rdata[2] = v_pat;
        step();
        rcb_ack = 4'b0000;
        for (int i = 0; i < NUM_RCB; i++) rcb_rdata[i] = {192{1'b0}};
        chk("rd_c3_rsp_valid", 192'(rsp_valid), 192'(1'b1));
        chk("rd_c3_status", 192'(rsp_status), 192'(2'd0));
        chk("rd_c3_data", rsp_data, a5_pat);
        chk("rd_c3_req", 192'(rcb_req), 192'(4'b0000));
        step();

        // 3. Decode errors
        dec_err_case("de_ram03", mk(8'h01, 8'h03, 17'h00010, 24'hFFFFFF, d_pat));
        dec_err_case("de_cmd07", mk(8'h07, 8'h01, 17'h00010, 24'hFFFFFF, d_pat));
        dec_err_case("de_addr1000", mk(8'h02, 8'h04, 17'h01000, 24'h000000, zero192));
        dec_err_case("de_addr16", mk(8'h02, 8'h01, 17'h10000, 24'h000000, zero192));
        dec_err_case("de_ram00", mk(8'h02, 8'h00, 17'h00000, 24'h000000, zero192));

        // 4. Backpressure on the response of a SRCB read
        rsp_ready = 1'b0;
        send("bp", mk(8'h02, 8'h01, 17'h00005, 24'h000000, zero192));
        step();
        rcb_ack = 4'b0001;
        rcb_rdata[0] = bp_pat;
        step();
        rcb_ack = 4'b0000;
        rcb_rdata[0] = zero192;
        host_msg   = mk(8'h01, 8'h02, 17'h00001, 24'h00000F, d_pat);
        host_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", 192'(rsp_valid), 192'(1'b1));
            chk("bp_rsp_data", rsp_data, bp_pat);
            chk("bp_status", 192'(rsp_status), 192'(2'd0));
            chk("bp_host_ready", 192'(host_ready), 192'(1'b0));
            chk("bp_req", 192'(rcb_req), 192'(4'b0000));
            step();
        end
        rsp_ready  = 1'b1;
        host_valid = 1'b0;
        step();
        chk("bp_rel_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        chk("bp_rel_host_ready", 192'(host_ready), 192'(1'b1));
        step();
        chk("bp_no_accept", 192'(host_ready), 192'(1'b1));
        chk("bp_no_req", 192'(rcb_req), 192'(4'b0000));

        // 5. Stray ack on lane 0 during a VRCB read
        send("stray", mk(8'h02, 8'h04, 17'h00100, 24'h000000, zero192));
        step();
        chk("stray_c2_req", 192'(rcb_req), 192'(4'b0100));
        rcb_ack = 4'b0001;
        rcb_rdata[0] = d_pat;
        step();
        rcb_ack = 4'b0000;
        rcb_rdata[0] = zero192;
        chk("stray_c3_req", 192'(rcb_req), 192'(4'b0100));
        chk("stray_c3_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        rcb_ack = 4'b0100;
        rcb_rdata[2] = v_pat;
        step();
        rcb_ack = 4'b0000;
        rcb_rdata[2] = zero192;
        chk("stray_done_valid", 192'(rsp_valid), 192'(1'b1));
        chk("stray_done_data", rsp_data, v_pat);
        chk("stray_done_req", 192'(rcb_req), 192'(4'b0000));
        step();

`ifdef TTS_CFG_TIMEOUT_EN
        // 6a. No ack: eight ISSUE cycles (2..9), then status 2 at cycle 10
        send("to", mk(8'h01, 8'h01, 17'h00020, 24'hFFFFFF, d_pat));
        step();
        for (int k = 2; k <= 9; k++) begin
            chk("to_req_held", 192'(rcb_req), 192'(4'b0001));
            step();
        end
        chk("to_req_drop", 192'(rcb_req), 192'(4'b0000));
        chk("to_rsp_valid", 192'(rsp_valid), 192'(1'b1));
        chk("to_status", 192'(rsp_status), 192'(2'd2));
        chk("to_data", rsp_data, zero192);
        step();
`endif

        // 6b. Reset during ISSUE
        send("rstmid", mk(8'h01, 8'h08, 17'h00ABC, 24'h123456, d_pat));
        step();
        chk("rstmid_c2_req", 192'(rcb_req), 192'(4'b1000));
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 192'(rcb_req), 192'(4'b0000));
        chk("rstmid_we", 192'(rcb_we), 192'(1'b0));
        chk("rstmid_addr", 192'(rcb_addr), 192'(16'h0000));
        chk("rstmid_be", 192'(rcb_byte_en), 192'(24'h000000));
        chk("rstmid_wdata", rcb_wdata, zero192);
        chk("rstmid_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        chk("rstmid_status", 192'(rsp_status), 192'(2'd0));
        chk("rstmid_data", rsp_data, zero192);
        chk("rstmid_host_ready", 192'(host_ready), 192'(1'b1));
        step();
        rst_n = 1'b1;
        rcb_ack = 4'b1000;
        step();
        rcb_ack = 4'b0000;
        chk("rstmid_post_rsp_valid", 192'(rsp_valid), 192'(1'b0));
        chk("rstmid_post_req", 192'(rcb_req), 192'(4'b0000));
        chk("rstmid_post_ready", 192'(host_ready), 192'(1'b1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
